// File: rtl/cpu_types_pkg.sv
// Shared core types: machine word, fetch FSM encoding and the IF/ID latch layout.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    typedef enum logic [1:0] {
        FETCH  = ST_FETCH,
        HOLD   = ST_HOLD,
        HALTED = ST_HALTED
    } fetch_state_t;

    typedef struct packed {
        word_t npc;
        word_t instr;
        logic  valid;
    } ifid_t;

    function automatic word_t pc_plus4(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/stage_if_if.sv
// Signal bundle between the fetch stage, its icache and the downstream control logic.
interface stage_if_if
    import cpu_types_pkg::*;
(
    input logic CLK,
    input logic RST
);
    logic  ihit;
    word_t imemload;
    logic  imemREN;
    word_t imemaddr;
    logic  stall_in;
    logic  flush_in;
    logic  redirect_valid;
    word_t redirect_pc;
    logic  halt_in;
    word_t npc_out;
    word_t imemload_out;
    logic  valid_out;

    modport fetch (
        input  CLK, RST, ihit, imemload, stall_in, flush_in,
               redirect_valid, redirect_pc, halt_in,
        output imemREN, imemaddr, npc_out, imemload_out, valid_out
    );
endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry holding slot for an instruction fetched while decode is stalled.
module fetch_hold_buf
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  load,
    input  logic  clear,
    input  word_t load_instr,
    input  word_t load_npc,
    output logic  valid,
    output word_t instr,
    output word_t npc
);

    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: the payload is reset as well as the valid bit, so a discarded
        // slot never carries X or a stale word into IF/ID.
        if (RST) begin
            valid <= 1'b0;
            instr <= '0;
            npc   <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            instr <= '0;
            npc   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            npc   <= load_npc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, talks to the icache and drives the IF/ID latch.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  ihit,
    input  word_t imemload,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  stall_in,
    input  logic  flush_in,
    input  logic  redirect_valid,
    input  word_t redirect_pc,
    input  logic  halt_in,
    output word_t npc_out,
    output word_t imemload_out,
    output logic  valid_out
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    logic         pend_valid_q, pend_valid_d;
    word_t        pend_pc_q, pend_pc_d;
    ifid_t        ifid_q, ifid_d;

    logic  buf_load, buf_clear, buf_valid;
    word_t buf_instr, buf_npc;
    word_t pc_next4;

    assign pc_next4 = pc_plus4(pc_q);

    fetch_hold_buf u_hold_buf (
        .CLK        (CLK),
        .RST        (RST),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_instr (imemload),
        .load_npc   (pc_next4),
        .valid      (buf_valid),
        .instr      (buf_instr),
        .npc        (buf_npc)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        buf_load     = 1'b0;
        buf_clear    = 1'b0;

        // IF/ID baseline: squash on flush, freeze on stall, otherwise a bubble.
        if (flush_in)      ifid_d = '0;
        else if (stall_in) ifid_d = ifid_q;
        else               ifid_d = '0;

        if (halt_in) begin
            state_d      = HALTED;
            ifid_d       = '0;
            buf_clear    = 1'b1;
            pend_valid_d = 1'b0;
            pend_pc_d    = '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (ihit) begin
                        if (redirect_valid) begin
                            pc_d         = redirect_pc;
                            pend_valid_d = 1'b0;
                        end else if (pend_valid_q) begin
                            pc_d         = pend_pc_q;
                            pend_valid_d = 1'b0;
                        end else if (flush_in) begin
                            // Word squashed with no new target: refetch the same PC.
                            pc_d = pc_q;
                        end else if (stall_in) begin
                            buf_load = 1'b1;
                            pc_d     = pc_next4;
                            state_d  = HOLD;
                        end else begin
                            ifid_d = '{npc: pc_next4, instr: imemload, valid: 1'b1};
                            pc_d   = pc_next4;
                        end
                    end else if (redirect_valid) begin
                        // The miss keeps its address; the target is applied on its hit.
                        pend_valid_d = 1'b1;
                        pend_pc_d    = redirect_pc;
                    end
                end
                HOLD: begin
                    if (redirect_valid || flush_in) begin
                        buf_clear    = 1'b1;
                        pend_valid_d = 1'b0;
                        if (redirect_valid) pc_d = redirect_pc;
                        state_d = FETCH;
                    end else if (!stall_in && buf_valid) begin
                        ifid_d    = '{npc: buf_npc, instr: buf_instr, valid: 1'b1};
                        buf_clear = 1'b1;
                        state_d   = FETCH;
                    end
                end
                default: begin
                    ifid_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: non-blocking assignments here, so every register samples the
        // pre-edge values computed above regardless of statement order.
        if (RST) begin
            state_q      <= FETCH;
            pc_q         <= PC_INIT;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
            ifid_q       <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            ifid_q       <= ifid_d;
        end
    end

    assign imemaddr     = pc_q;
    assign imemREN      = (state_q == FETCH);
    assign npc_out      = ifid_q.npc;
    assign imemload_out = ifid_q.instr;
    assign valid_out    = ifid_q.valid;

endmodule
